mem_bus_arbiter: RTL and testbench

//  Shares one downstream memory port between instruction-cache and data-cache miss/writeback requests.

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter_watchdog.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the L1 icache/dcache to memory bus arbiter.
// Holds the FSM state and transaction owner encodings plus the default watchdog limit.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } owner_t;

  localparam int ARB_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Busy-cycle counter that flags a memory which never acks.
// Ports: clock, reset (async high), clear, enable in; expired out (count == TIMEOUT-1).
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between icache and dcache, one transaction at a time.
// Ports: i_*/d_* requester sides, mem_* downstream port, owner monitor tap; all outputs registered.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 32,
  parameter int TIMEOUT      = ARB_TIMEOUT_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [ADDRESSWIDTH-1:0] i_addr,
  input  logic [DATAWIDTH-1:0]    i_wdata,
  output logic                    i_done,
  output logic                    i_err,
  output logic [DATAWIDTH-1:0]    i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDRESSWIDTH-1:0] d_addr,
  input  logic [DATAWIDTH-1:0]    d_wdata,
  output logic                    d_done,
  output logic                    d_err,
  output logic [DATAWIDTH-1:0]    d_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0]    mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATAWIDTH-1:0]    mem_rdata,
  output logic [1:0]              owner
);

  arb_state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t last_q, last_d;
  owner_t win;

  logic mreq_q, mreq_d;
  logic mwe_q, mwe_d;
  logic [ADDRESSWIDTH-1:0] maddr_q, maddr_d;
  logic [DATAWIDTH-1:0] mwd_q, mwd_d;
  logic [DATAWIDTH-1:0] ird_q, ird_d;
  logic [DATAWIDTH-1:0] drd_q, drd_d;
  logic idone_q, idone_d, ierr_q, ierr_d;
  logic ddone_q, ddone_d, derr_q, derr_d;

  logic pick_d;
  logic fin, fin_err;
  logic [DATAWIDTH-1:0] fin_data;
  logic wd_clr, wd_en, expired;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clr),
    .enable  (wd_en),
    .expired (expired)
  );

  // On a tie the requester that did not win last time goes first.
  assign pick_d = d_req & (~i_req | (last_q == OWN_INSTR));
  assign win    = pick_d ? OWN_DATA : OWN_INSTR;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwd_d    = mwd_q;
    ird_d    = ird_q;
    drd_d    = drd_q;
    ierr_d   = ierr_q;
    derr_d   = derr_q;
    idone_d  = 1'b0;
    ddone_d  = 1'b0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
    unique case (state_q)
      ARB_IDLE: begin
        owner_d = OWN_NONE;
        if (i_req | d_req) begin
          state_d = ARB_BUSY;
          owner_d = win;
          last_d  = win;
          mreq_d  = 1'b1;
          wd_clr  = 1'b1;
          mwe_d   = pick_d ? d_we : i_we;
          maddr_d = pick_d ? d_addr : i_addr;
          mwd_d   = pick_d ? d_wdata : i_wdata;
        end
      end
      ARB_BUSY: begin
        wd_en = 1'b1;
        // An ack in the last watchdog cycle still wins.
        if (mem_ack) begin
          fin      = 1'b1;
          fin_data = mem_rdata;
        end else if (expired) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
    if (fin) begin
      state_d = ARB_DONE;
      mreq_d  = 1'b0;
      if (owner_q == OWN_INSTR) begin
        idone_d = 1'b1;
        ird_d   = fin_data;
        ierr_d  = fin_err;
      end else begin
        ddone_d = 1'b1;
        drd_d   = fin_data;
        derr_d  = fin_err;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      last_q  <= OWN_INSTR;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mwd_q   <= '0;
      ird_q   <= '0;
      drd_q   <= '0;
      ierr_q  <= 1'b0;
      derr_q  <= 1'b0;
      idone_q <= 1'b0;
      ddone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      mreq_q  <= mreq_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
      ird_q   <= ird_d;
      drd_q   <= drd_d;
      ierr_q  <= ierr_d;
      derr_q  <= derr_d;
      idone_q <= idone_d;
      ddone_q <= ddone_d;
    end
  end

  assign mem_req   = mreq_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwd_q;
  assign i_done    = idone_q;
  assign i_err     = ierr_q;
  assign i_rdata   = ird_q;
  assign d_done    = ddone_q;
  assign d_err     = derr_q;
  assign d_rdata   = drd_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: timeline model of transactions, directed steps then random traffic.
// A second instance with TIMEOUT=8 exercises the watchdog boundary.
module tb_mem_bus_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic i_req, i_we, i_done, i_err;
  logic [31:0] i_addr, i_wdata, i_rdata;
  logic d_req, d_we, d_done, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] owner;

  logic w_i_req, w_i_we, w_i_done, w_i_err;
  logic [31:0] w_i_addr, w_i_wdata, w_i_rdata;
  logic w_d_req, w_d_we, w_d_done, w_d_err;
  logic [31:0] w_d_addr, w_d_wdata, w_d_rdata;
  logic w_mem_req, w_mem_we, w_mem_ack;
  logic [31:0] w_mem_addr, w_mem_wdata, w_mem_rdata;
  logic [1:0] w_owner;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  mem_bus_arbiter #(.TIMEOUT(8)) dut_wd (
    .clock(clock), .reset(reset),
    .i_req(w_i_req), .i_we(w_i_we), .i_addr(w_i_addr), .i_wdata(w_i_wdata),
    .i_done(w_i_done), .i_err(w_i_err), .i_rdata(w_i_rdata),
    .d_req(w_d_req), .d_we(w_d_we), .d_addr(w_d_addr), .d_wdata(w_d_wdata),
    .d_done(w_d_done), .d_err(w_d_err), .d_rdata(w_d_rdata),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata),
    .owner(w_owner)
  );

  int total = 0;
  int bad = 0;

  // Model: owners 0 none, 1 icache, 2 dcache; times are negedge indices.
  int n, cur, last, g_n, a_n, free_n, next_k, rate;
  bit k_rnd, spur, just_i, just_d, prev_req;
  logic ipend, dpend, iwe, dwe, cwe;
  logic [31:0] iaddr, iwd, daddr, dwd, caddr, cwd;
  logic [31:0] ack_data, next_data, exp_ird, exp_drd;
  logic exp_ierr, exp_derr;
  int lowcnt, hicnt, b;
  int oseq[$];
  int gaps[$];
  int blen[$];

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    cur = 0; last = 1;
    exp_ird = '0; exp_drd = '0; exp_ierr = 1'b0; exp_derr = 1'b0;
    prev_req = 1'b0; lowcnt = 0; hicnt = 0;
  endtask

  task automatic observe();
    logic bz, dn;
    int eo;
    @(negedge clock);
    n++;
    bz = (cur != 0) && (n >= g_n) && (n <= a_n);
    dn = (cur != 0) && (n == a_n + 1);
    eo = ((cur != 0) && (n >= g_n)) ? cur : 0;
    if (dn && cur == 1) begin exp_ird = ack_data; exp_ierr = 1'b0; end
    if (dn && cur == 2) begin exp_drd = ack_data; exp_derr = 1'b0; end
    chk("mem_req", 32'(mem_req), 32'(bz));
    chk("owner", 32'(owner), 32'(eo));
    chk("i_done", 32'(i_done), 32'(dn && cur == 1));
    chk("d_done", 32'(d_done), 32'(dn && cur == 2));
    chk("i_rdata", i_rdata, exp_ird);
    chk("i_err", 32'(i_err), 32'(exp_ierr));
    chk("d_rdata", d_rdata, exp_drd);
    chk("d_err", 32'(d_err), 32'(exp_derr));
    if (bz) begin
      chk("mem_addr", mem_addr, caddr);
      chk("mem_wdata", mem_wdata, cwd);
      chk("mem_we", 32'(mem_we), 32'(cwe));
    end
    if (mem_req && !prev_req) begin
      oseq.push_back(int'(owner)); gaps.push_back(lowcnt); hicnt = 0;
    end
    if (!mem_req && prev_req) begin blen.push_back(hicnt); lowcnt = 0; end
    if (mem_req) hicnt++; else lowcnt++;
    prev_req = mem_req;
    just_i = 1'b0; just_d = 1'b0;
    if (dn) begin
      if (cur == 1) begin ipend = 1'b0; just_i = 1'b1; end
      else begin dpend = 1'b0; just_d = 1'b1; end
      last = cur; cur = 0; free_n = n + 1;
    end
  endtask

  task automatic drive();
    int w;
    if (rate > 0 && !ipend && !just_i && $urandom_range(99) < rate) begin
      ipend = 1'b1; iwe = 1'($urandom_range(1)); iaddr = $urandom; iwd = $urandom;
    end
    if (rate > 0 && !dpend && !just_d && $urandom_range(99) < rate) begin
      dpend = 1'b1; dwe = 1'($urandom_range(1)); daddr = $urandom; dwd = $urandom;
    end
    if (cur == 0 && n >= free_n && (ipend || dpend)) begin
      if (ipend && dpend) w = (last == 1) ? 2 : 1;
      else w = dpend ? 2 : 1;
      cur = w; g_n = n + 1; a_n = g_n + next_k - 1; ack_data = next_data;
      if (w == 1) begin cwe = iwe; caddr = iaddr; cwd = iwd; end
      else begin cwe = dwe; caddr = daddr; cwd = dwd; end
      if (k_rnd) next_k = $urandom_range(1, 6);
      next_data = $urandom;
    end
    i_req = ipend; i_we = iwe; i_addr = iaddr; i_wdata = iwd;
    d_req = dpend; d_we = dwe; d_addr = daddr; d_wdata = dwd;
    // The owner's inputs are don't-care once granted.
    if (cur == 1 && n >= g_n) begin i_addr = $urandom; i_wdata = $urandom; end
    if (cur == 2 && n >= g_n) begin d_addr = $urandom; d_wdata = $urandom; end
    mem_rdata = $urandom;
    mem_ack = 1'b0;
    if (cur != 0 && n == a_n) begin
      mem_ack = 1'b1; mem_rdata = ack_data;
    end else if (spur && !(cur != 0 && n >= g_n)) begin
      mem_ack = 1'($urandom_range(1));
    end
  endtask

  task automatic tick();
    observe();
    drive();
  endtask

  task automatic settle();
    int c = 0;
    while ((cur != 0 || ipend || dpend) && c < 300) begin
      tick();
      c++;
    end
    chk("settle_bound", 32'(c < 300), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_bound reached");
    $fatal(1, "time bound");
  end

  initial begin
    n = 0; free_n = 0; g_n = 0; a_n = 0; rate = 0; k_rnd = 0; spur = 0;
    next_k = 2; next_data = $urandom; model_reset();
    ipend = 0; dpend = 0; iwe = 0; dwe = 0;
    iaddr = '0; iwd = '0; daddr = '0; dwd = '0;
    caddr = '0; cwd = '0; cwe = 0; ack_data = '0;
    i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    w_i_req = 0; w_i_we = 0; w_i_addr = '0; w_i_wdata = '0;
    w_d_req = 0; w_d_we = 0; w_d_addr = '0; w_d_wdata = '0;
    w_mem_ack = 0; w_mem_rdata = '0;

    // Async reset before any clock edge.
    #1 reset = 1'b1;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_i_done", 32'(i_done), 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_w_mem_req", 32'(w_mem_req), 32'd0);
    @(negedge clock); n++;
    @(negedge clock); n++;
    reset = 1'b0; free_n = n;
    drive();

    // Tie straight after reset: dcache first, then icache.
    b = oseq.size();
    ipend = 1; iwe = 0; iaddr = 32'h0000_2000;
    dpend = 1; dwe = 0; daddr = 32'h0000_3000;
    next_k = 2;
    settle();
    chk("tie_count", 32'(oseq.size() - b), 32'd2);
    if (oseq.size() >= b + 2) begin
      chk("tie_first", 32'(oseq[b]), 32'd2);
      chk("tie_second", 32'(oseq[b+1]), 32'd1);
      chk("tie_gap", 32'(gaps[b+1]), 32'd2);
    end

    // Lone dcache read.
    dpend = 1; dwe = 0; daddr = 32'h0000_1000;
    next_k = 3; next_data = 32'h0BEE_FA55;
    settle();
    chk("dread_rdata", d_rdata, 32'h0BEE_FA55);
    chk("dread_busy_len", 32'(blen[blen.size()-1]), 32'd3);

    // icache write held for 10 busy cycles.
    ipend = 1; iwe = 1; iaddr = 32'hFFFF_FFFC; iwd = 32'hA5A5_A5A5;
    next_k = 10;
    settle();
    chk("write_busy_len", 32'(blen[blen.size()-1]), 32'd10);

    // Sustained contention, ack latency 1.
    b = oseq.size(); next_k = 1; rate = 100;
    for (int c = 0; c < 200 && oseq.size() < b + 6; c++) tick();
    rate = 0;
    settle();
    chk("cont_count", 32'(oseq.size() >= b + 6), 32'd1);
    if (oseq.size() >= b + 6) begin
      for (int j = 0; j < 6; j++) begin
        chk("cont_owner", 32'(oseq[b+j]), (j % 2 == 0) ? 32'd2 : 32'd1);
        if (j > 0) chk("cont_gap", 32'(gaps[b+j]), 32'd2);
      end
    end

    // Watchdog on the TIMEOUT=8 instance: ack in the final cycle succeeds.
    w_i_req = 1; w_i_we = 0; w_i_addr = 32'h0000_0040;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("wd_busy", 32'(w_mem_req), 32'd1);
      chk("wd_addr", w_mem_addr, 32'h0000_0040);
      chk("wd_nodone", 32'(w_i_done), 32'd0);
      if (c == 8) begin w_mem_ack = 1; w_mem_rdata = 32'h1234_5678; end
    end
    tick();
    w_mem_ack = 0;
    chk("wd_ack_done", 32'(w_i_done), 32'd1);
    chk("wd_ack_err", 32'(w_i_err), 32'd0);
    chk("wd_ack_rdata", w_i_rdata, 32'h1234_5678);
    chk("wd_ack_req", 32'(w_mem_req), 32'd0);
    w_i_req = 0;
    tick();
    w_i_req = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("wd_busy2", 32'(w_mem_req), 32'd1);
      chk("wd_nodone2", 32'(w_i_done), 32'd0);
      chk("wd_hold_rdata", w_i_rdata, 32'h1234_5678);
    end
    tick();
    chk("wd_to_done", 32'(w_i_done), 32'd1);
    chk("wd_to_err", 32'(w_i_err), 32'd1);
    chk("wd_to_rdata", w_i_rdata, 32'd0);
    w_i_req = 0;
    tick();
    chk("wd_pulse", 32'(w_i_done), 32'd0);
    chk("wd_owner", 32'(w_owner), 32'd0);

    // Random traffic with spurious acks outside busy.
    rate = 30; k_rnd = 1; spur = 1; next_k = 3;
    for (int c = 0; c < 400; c++) tick();
    rate = 0; spur = 0;
    settle();

    // Reset in the middle of an icache transaction with dcache waiting.
    k_rnd = 0; next_k = 30;
    ipend = 1; iwe = 0; iaddr = 32'h0000_5000;
    for (int c = 0; c < 50 && !(cur == 1 && n >= g_n + 2); c++) tick();
    chk("rst_setup", 32'(cur == 1 && n >= g_n + 2), 32'd1);
    dpend = 1; dwe = 1; daddr = 32'h0000_6000; dwd = 32'h0BAD_CAFE;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rstb_mem_req", 32'(mem_req), 32'd0);
    chk("rstb_owner", 32'(owner), 32'd0);
    chk("rstb_i_done", 32'(i_done), 32'd0);
    chk("rstb_d_done", 32'(d_done), 32'd0);
    model_reset();
    mem_ack = 0;
    @(negedge clock); n++;
    @(negedge clock); n++;
    reset = 1'b0; free_n = n; next_k = 2;
    b = oseq.size();
    drive();
    settle();
    chk("rstb_count", 32'(oseq.size() - b), 32'd2);
    if (oseq.size() >= b + 2) begin
      chk("rstb_first", 32'(oseq[b]), 32'd2);
      chk("rstb_second", 32'(oseq[b+1]), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
